u_alu_op_issue: RTL and testbench

// - Issue-side producer for the EX-stage ALU planes; consumes OP/OP-IMM instructions and register data from ID.
// - Decodes each instruction into one-hot plane flags (and/or/xor, add/sub, shifts, slt/sltu).
// - Supplies operand pair + flags to logic/arith/shift planes; plane outputs are OR-combined by flag.
// - Registered valid/ready stage with 1-entry skid buffer; handles back-pressure and flush.

---
 rtl/u_alu_op_issue_pkg.sv | 51 +++++
 rtl/u_alu_op_issue_decode.sv | 61 ++++++
 rtl/u_alu_op_issue.sv | 101 ++++++++++
 tb/tb_u_alu_op_issue.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/u_alu_op_issue_pkg.sv
// Shared decode constants for the ALU issue stage: opcodes, funct codes and plane flag indices.
package u_alu_op_issue_pkg;

    localparam int unsigned INSTR_WIDTH = 32;
    localparam int unsigned ALU_FLAG_W  = 10;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam int unsigned ALU_F_AND  = 0;
    localparam int unsigned ALU_F_OR   = 1;
    localparam int unsigned ALU_F_XOR  = 2;
    localparam int unsigned ALU_F_ADD  = 3;
    localparam int unsigned ALU_F_SUB  = 4;
    localparam int unsigned ALU_F_SLL  = 5;
    localparam int unsigned ALU_F_SRL  = 6;
    localparam int unsigned ALU_F_SRA  = 7;
    localparam int unsigned ALU_F_SLT  = 8;
    localparam int unsigned ALU_F_SLTU = 9;

    function automatic logic [ALU_FLAG_W-1:0] flag_bit(input int unsigned idx);
        return ALU_FLAG_W'(1) << idx;
    endfunction

    // Flag selected by funct3 alone (the non-alternate variant of add/sub and srl/sra).
    function automatic logic [ALU_FLAG_W-1:0] base_flag(input logic [2:0] funct3);
        case (funct3)
            F3_ADD_SUB: return flag_bit(ALU_F_ADD);
            F3_SLL:     return flag_bit(ALU_F_SLL);
            F3_SLT:     return flag_bit(ALU_F_SLT);
            F3_SLTU:    return flag_bit(ALU_F_SLTU);
            F3_XOR:     return flag_bit(ALU_F_XOR);
            F3_SRL_SRA: return flag_bit(ALU_F_SRL);
            F3_OR:      return flag_bit(ALU_F_OR);
            default:    return flag_bit(ALU_F_AND);
        endcase
    endfunction

endpackage

// File: rtl/u_alu_op_issue_decode.sv
// Combinational decode of an OP/OP-IMM instruction into one-hot plane flags and operands.
module u_alu_op_decode_comb
    import u_alu_op_issue_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic [DATA_WIDTH-1:0]  rs1_data,
    input  logic [DATA_WIDTH-1:0]  rs2_data,
    output logic [ALU_FLAG_W-1:0]  flags_c,
    output logic [DATA_WIDTH-1:0]  op1_c,
    output logic [DATA_WIDTH-1:0]  op2_c,
    output logic                   illegal_c
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_shift;
    logic       unused_fields;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign is_shift = (funct3 == F3_SLL) || (funct3 == F3_SRL_SRA);
    assign unused_fields = ^{instr[19:15], instr[11:7]};

    always_comb begin
        flags_c   = '0;
        illegal_c = 1'b0;
        op1_c     = rs1_data;
        op2_c     = rs2_data;
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    flags_c = base_flag(funct3);
                end else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
                    flags_c = flag_bit(ALU_F_SUB);
                end else if (funct7 == F7_ALT && funct3 == F3_SRL_SRA) begin
                    flags_c = flag_bit(ALU_F_SRA);
                end else begin
                    illegal_c = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                // Shifts take a 5-bit shamt; everything else a sign-extended 12-bit immediate.
                op2_c = is_shift ? DATA_WIDTH'(instr[24:20])
                                 : DATA_WIDTH'($signed(instr[31:20]));
                if (!is_shift || funct7 == F7_BASE) begin
                    flags_c = base_flag(funct3);
                end else if (funct3 == F3_SRL_SRA && funct7 == F7_ALT) begin
                    flags_c = flag_bit(ALU_F_SRA);
                end else begin
                    illegal_c = 1'b1;
                end
            end
            default: illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/u_alu_op_issue.sv
// ALU issue stage: decode, registered output entry and a one-entry skid buffer toward EX.
module u_alu_op_issue
    import u_alu_op_issue_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_vld,
    input  logic [INSTR_WIDTH-1:0] id_instr,
    input  logic [DATA_WIDTH-1:0]  id_rs1_data,
    input  logic [DATA_WIDTH-1:0]  id_rs2_data,
    output logic                   issue_ready,
    input  logic                   ex_ready,
    input  logic                   ex_flush,
    output logic                   ex_vld,
    output logic [DATA_WIDTH-1:0]  ex_data_in_1,
    output logic [DATA_WIDTH-1:0]  ex_data_in_2,
    output logic [ALU_FLAG_W-1:0]  ex_flags,
    output logic                   ex_illegal
);

    logic [ALU_FLAG_W-1:0] dec_flags;
    logic [DATA_WIDTH-1:0] dec_op1;
    logic [DATA_WIDTH-1:0] dec_op2;
    logic                  dec_illegal;

    logic                  skid_vld;
    logic [DATA_WIDTH-1:0] skid_op1;
    logic [DATA_WIDTH-1:0] skid_op2;
    logic [ALU_FLAG_W-1:0] skid_flags;
    logic                  skid_illegal;

    logic accept;
    logic fire;

    u_alu_op_decode_comb #(.DATA_WIDTH(DATA_WIDTH)) u_decode (
        .instr     (id_instr),
        .rs1_data  (id_rs1_data),
        .rs2_data  (id_rs2_data),
        .flags_c   (dec_flags),
        .op1_c     (dec_op1),
        .op2_c     (dec_op2),
        .illegal_c (dec_illegal)
    );

    assign accept = id_vld & issue_ready;
    assign fire   = ex_vld & ex_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_vld       <= 1'b0;
            ex_data_in_1 <= '0;
            ex_data_in_2 <= '0;
            ex_flags     <= '0;
            ex_illegal   <= 1'b0;
            skid_vld     <= 1'b0;
            skid_op1     <= '0;
            skid_op2     <= '0;
            skid_flags   <= '0;
            skid_illegal <= 1'b0;
            issue_ready  <= 1'b1;
        end else if (ex_flush) begin
            // Operands may stay stale; flags are cleared so they read zero while invalid.
            ex_vld      <= 1'b0;
            ex_flags    <= '0;
            ex_illegal  <= 1'b0;
            skid_vld    <= 1'b0;
            issue_ready <= 1'b1;
        end else if (fire || !ex_vld) begin
            if (skid_vld) begin
                ex_vld       <= 1'b1;
                ex_data_in_1 <= skid_op1;
                ex_data_in_2 <= skid_op2;
                ex_flags     <= skid_flags;
                ex_illegal   <= skid_illegal;
                skid_vld     <= 1'b0;
                issue_ready  <= 1'b1;
            end else if (accept) begin
                ex_vld       <= 1'b1;
                ex_data_in_1 <= dec_op1;
                ex_data_in_2 <= dec_op2;
                ex_flags     <= dec_flags;
                ex_illegal   <= dec_illegal;
            end else begin
                ex_vld     <= 1'b0;
                ex_flags   <= '0;
                ex_illegal <= 1'b0;
            end
        end else if (accept) begin
            // Output is stalled: park the new entry behind it.
            skid_vld     <= 1'b1;
            skid_op1     <= dec_op1;
            skid_op2     <= dec_op2;
            skid_flags   <= dec_flags;
            skid_illegal <= dec_illegal;
            issue_ready  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_u_alu_op_issue.sv
// Bench for u_alu_op_issue: directed decode/flow scenarios plus randomized traffic vs a queue model.
module tb_u_alu_op_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_vld;
    logic [31:0] id_instr;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic        issue_ready;
    logic        ex_ready;
    logic        ex_flush;
    logic        ex_vld;
    logic [31:0] ex_data_in_1;
    logic [31:0] ex_data_in_2;
    logic [9:0]  ex_flags;
    logic        ex_illegal;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [9:0]  flags;
        logic        illegal;
    } entry_t;

    entry_t q[$];

    always #5 clk = ~clk;

    u_alu_op_issue #(.DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_vld       (id_vld),
        .id_instr     (id_instr),
        .id_rs1_data  (id_rs1_data),
        .id_rs2_data  (id_rs2_data),
        .issue_ready  (issue_ready),
        .ex_ready     (ex_ready),
        .ex_flush     (ex_flush),
        .ex_vld       (ex_vld),
        .ex_data_in_1 (ex_data_in_1),
        .ex_data_in_2 (ex_data_in_2),
        .ex_flags     (ex_flags),
        .ex_illegal   (ex_illegal)
    );

    // Reference decode: flag index 0..9 = and,or,xor,add,sub,sll,srl,sra,slt,sltu.
    function automatic entry_t ref_model(input logic [31:0] instr, input logic [31:0] rs1,
                                         input logic [31:0] rs2);
        entry_t     e;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        int         idx;
        opc   = instr[6:0];
        f3    = instr[14:12];
        f7    = instr[31:25];
        idx   = -1;
        e.op1 = rs1;
        e.op2 = rs2;
        if (opc == 7'h33) begin
            case ({f7, f3})
                {7'h00, 3'd0}: idx = 3;
                {7'h20, 3'd0}: idx = 4;
                {7'h00, 3'd1}: idx = 5;
                {7'h00, 3'd2}: idx = 8;
                {7'h00, 3'd3}: idx = 9;
                {7'h00, 3'd4}: idx = 2;
                {7'h00, 3'd5}: idx = 6;
                {7'h20, 3'd5}: idx = 7;
                {7'h00, 3'd6}: idx = 1;
                {7'h00, 3'd7}: idx = 0;
                default:       idx = -1;
            endcase
        end else if (opc == 7'h13) begin
            if (f3 == 3'd1 || f3 == 3'd5) e.op2 = {27'b0, instr[24:20]};
            else                          e.op2 = {{20{instr[31]}}, instr[31:20]};
            case (f3)
                3'd0: idx = 3;
                3'd1: idx = (f7 == 7'h00) ? 5 : -1;
                3'd2: idx = 8;
                3'd3: idx = 9;
                3'd4: idx = 2;
                3'd5: idx = (f7 == 7'h00) ? 6 : ((f7 == 7'h20) ? 7 : -1);
                3'd6: idx = 1;
                default: idx = 0;
            endcase
        end
        e.illegal = (idx < 0);
        e.flags   = (idx < 0) ? 10'd0 : (10'd1 << idx);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        int          k;
        logic [6:0]  f7;
        logic [6:0]  opc;
        k   = int'($urandom_range(0, 9));
        f7  = (k < 5) ? 7'h00 : ((k < 8) ? 7'h20 : 7'($urandom));
        opc = (k % 3 == 0) ? 7'h13 : ((k == 7) ? 7'($urandom) : 7'h33);
        return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opc};
    endfunction

    // One clock: drive inputs, check state against the model mid-cycle, then advance.
    task automatic cycle(input logic vld, input logic [31:0] instr, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic rdy, input logic fl, input logic r);
        entry_t exp;
        int     held;
        logic   inv_ok;
        id_vld      = vld;
        id_instr    = instr;
        id_rs1_data = rs1;
        id_rs2_data = rs2;
        ex_ready    = rdy;
        ex_flush    = fl;
        rst         = r;
        #4;
        if (r) begin
            q.delete();
        end else begin
            held = q.size();
            tests++;
            if (ex_vld !== 1'(held > 0)) begin
                fails++;
                $display("FAIL ex_vld_model: got %b expected %b", ex_vld, held > 0);
            end
            tests++;
            if (issue_ready !== 1'(held < 2)) begin
                fails++;
                $display("FAIL issue_ready_model: got %b expected %b", issue_ready, held < 2);
            end
            inv_ok = ex_vld ? (ex_illegal ? (ex_flags == 10'd0) : ($countones(ex_flags) == 1))
                            : (ex_flags == 10'd0);
            tests++;
            if (!inv_ok) begin
                fails++;
                $display("FAIL flag_invariant: vld=%b illegal=%b flags=%h required one-hot or zero",
                         ex_vld, ex_illegal, ex_flags);
            end
            if (fl) begin
                q.delete();
            end else begin
                if (rdy && held > 0) begin
                    exp = q.pop_front();
                    tests++;
                    if ({ex_data_in_1, ex_data_in_2, ex_flags, ex_illegal} !==
                        {exp.op1, exp.op2, exp.flags, exp.illegal}) begin
                        fails++;
                        $display("FAIL fire_entry: got op1=%h op2=%h fl=%h ill=%b expected op1=%h op2=%h fl=%h ill=%b",
                                 ex_data_in_1, ex_data_in_2, ex_flags, ex_illegal,
                                 exp.op1, exp.op2, exp.flags, exp.illegal);
                    end
                end
                if (vld && held < 2) q.push_back(ref_model(instr, rs1, rs2));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 32'h0, 32'h0, 32'h0, rdy, 1'b0, 1'b0);
    endtask

    task automatic check_cleared(input string name);
        tests++;
        if ({ex_vld, issue_ready, ex_flags, ex_illegal, ex_data_in_1, ex_data_in_2} !==
            {1'b0, 1'b1, 10'd0, 1'b0, 32'd0, 32'd0}) begin
            fails++;
            $display("FAIL %s: got vld=%b rdy=%b fl=%h ill=%b op1=%h op2=%h expected all zero, rdy=1",
                     name, ex_vld, issue_ready, ex_flags, ex_illegal, ex_data_in_1, ex_data_in_2);
        end
    endtask

    task automatic test_reset();
        cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        check_cleared("reset_state");
    endtask

    task automatic test_decode();
        cycle(1'b1, 32'h0020F1B3, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 1'b0, 1'b0);
        tests++;
        if ({ex_vld, ex_flags, ex_data_in_2} !== {1'b1, 10'h001, 32'hFF00FF00}) begin
            fails++;
            $display("FAIL and_decode: got vld=%b fl=%h op2=%h expected 1 001 ff00ff00", ex_vld, ex_flags, ex_data_in_2);
        end
        cycle(1'b1, 32'hFFF0C193, 32'h12345678, 32'h0, 1'b1, 1'b0, 1'b0);
        tests++;
        if ({ex_flags, ex_data_in_2} !== {10'h004, 32'hFFFFFFFF}) begin
            fails++;
            $display("FAIL xori_decode: got fl=%h op2=%h expected 004 ffffffff", ex_flags, ex_data_in_2);
        end
        cycle(1'b1, 32'h4020D193, 32'h80000000, 32'h7, 1'b1, 1'b0, 1'b0);
        tests++;
        if ({ex_flags, ex_data_in_2} !== {10'h080, 32'h2}) begin
            fails++;
            $display("FAIL srai_decode: got fl=%h op2=%h expected 080 00000002", ex_flags, ex_data_in_2);
        end
        cycle(1'b1, 32'h40008193, 32'h1, 32'h9, 1'b1, 1'b0, 1'b0);
        tests++;
        if ({ex_flags, ex_illegal, ex_data_in_2} !== {10'h008, 1'b0, 32'h400}) begin
            fails++;
            $display("FAIL addi_bit30: got fl=%h ill=%b op2=%h expected 008 0 00000400", ex_flags, ex_illegal, ex_data_in_2);
        end
        cycle(1'b1, 32'h0200C1B3, 32'hAAAA5555, 32'h5555AAAA, 1'b1, 1'b0, 1'b0);
        tests++;
        if ({ex_vld, ex_illegal, ex_flags, ex_data_in_1} !== {1'b1, 1'b1, 10'h0, 32'hAAAA5555}) begin
            fails++;
            $display("FAIL illegal_funct7: got vld=%b ill=%b fl=%h op1=%h expected 1 1 000 aaaa5555",
                     ex_vld, ex_illegal, ex_flags, ex_data_in_1);
        end
        cycle(1'b1, 32'h0000A183, 32'h3, 32'h4, 1'b1, 1'b0, 1'b0);
        tests++;
        if ({ex_vld, ex_illegal, ex_flags} !== {1'b1, 1'b1, 10'h0}) begin
            fails++;
            $display("FAIL illegal_opcode: got vld=%b ill=%b fl=%h expected 1 1 000", ex_vld, ex_illegal, ex_flags);
        end
        idle(1'b1);
    endtask

    task automatic test_back_to_back();
        cycle(1'b1, 32'h002081B3, 32'h11, 32'h22, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h402081B3, 32'h33, 32'h44, 1'b0, 1'b0, 1'b0);
        tests++;
        if ({ex_vld, issue_ready} !== 2'b10) begin
            fails++;
            $display("FAIL backpressure_full: got vld=%b rdy=%b expected 1 0", ex_vld, issue_ready);
        end
        cycle(1'b1, 32'h0020E1B3, 32'h55, 32'h66, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        tests++;
        if ({ex_vld, issue_ready} !== 2'b01 || q.size() != 0) begin
            fails++;
            $display("FAIL backpressure_drain: got vld=%b rdy=%b left=%0d expected 0 1 0", ex_vld, issue_ready, q.size());
        end
    endtask

    task automatic test_flush();
        cycle(1'b1, 32'h0020F1B3, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0020E1B3, 32'h3, 32'h4, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0020C1B3, 32'hDEAD, 32'hBEEF, 1'b0, 1'b1, 1'b0);
        tests++;
        if ({ex_vld, issue_ready, ex_flags} !== {1'b0, 1'b1, 10'h0}) begin
            fails++;
            $display("FAIL flush_clear: got vld=%b rdy=%b fl=%h expected 0 1 000", ex_vld, issue_ready, ex_flags);
        end
        idle(1'b1);
        idle(1'b1);
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 32'h0020F1B3, 32'h77, 32'h88, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0020E1B3, 32'h99, 32'hAA, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0020C1B3, 32'hBB, 32'hCC, 1'b0, 1'b0, 1'b1);
        check_cleared("reset_mid");
        idle(1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), rand_instr(), $urandom, $urandom,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 29) == 0), 1'b0);
        end
        for (int i = 0; i < 4; i++) idle(1'b1);
    endtask

    initial begin
        id_vld = 1'b0; id_instr = '0; id_rs1_data = '0; id_rs2_data = '0;
        ex_ready = 1'b0; ex_flush = 1'b0; rst = 1'b1;
        test_reset();
        test_decode();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
